// File: rtl/platform_pkg.sv
// platform_pkg: shared types, default geometry and LFSR step for the platform scheduler.
//   Contents: state_t FSM encoding, coord_t signed screen coordinate,
//   DEF_* parameter defaults, LFSR_SEED and lfsr_step (x^15 + x^14 + 1).
package platform_pkg;
    typedef enum logic [1:0] {IDLE, SCROLL, SCAN, RECYCLE} state_t;
    typedef logic signed [10:0] coord_t;
    localparam coord_t DEF_EARTH = 11'sd480;
    localparam coord_t DEF_SCROLL_DY = 11'sd12;
    localparam int DEF_SCROLL_FRAMES = 16;
    localparam int DEF_GROUPS = 6;
    localparam int DEF_GROUP_SIZE = 15;
    localparam logic [14:0] LFSR_SEED = 15'h4A5;
    function automatic logic [14:0] lfsr_step(input logic [14:0] v);
        return {v[13:0], v[14] ^ v[13]};
    endfunction
endpackage

// File: rtl/platform_scheduler_if.sv
// platform_scheduler_if: command/status bundle between the scheduler and the platform datapath.
//   master: scheduler side (drives scroll/recycle commands and status).
//   slave:  datapath side (drives frame_tick, collision, group_y, recycle_ready).
interface platform_scheduler_if import platform_pkg::*; #(
    parameter int GROUPS = DEF_GROUPS,
    parameter int GROUP_SIZE = DEF_GROUP_SIZE
);
    logic                  frame_tick;
    logic                  collision;
    coord_t                group_y [GROUPS];
    logic                  scroll_valid;
    coord_t                scroll_dy;
    logic                  recycle_valid;
    logic                  recycle_ready;
    logic [2:0]            recycle_group;
    logic [GROUP_SIZE-1:0] recycle_mask;
    logic                  busy;
    logic                  overrun;
    logic [15:0]           score;
    modport master (
        input  frame_tick, collision, group_y, recycle_ready,
        output scroll_valid, scroll_dy, recycle_valid, recycle_group, recycle_mask, busy, overrun, score
    );
    modport slave (
        output frame_tick, collision, group_y, recycle_ready,
        input  scroll_valid, scroll_dy, recycle_valid, recycle_group, recycle_mask, busy, overrun, score
    );
endinterface

// File: rtl/platform_lfsr.sv
// platform_lfsr: free-running 15-bit Fibonacci LFSR (x^15 + x^14 + 1), seeded on reset.
//   clk, rst: clock and synchronous active-high reset
//   value_o:  current LFSR state, advances every clock
module platform_lfsr import platform_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    output logic [14:0] value_o
);
    always_ff @(posedge clk) begin
        value_o <= rst ? LFSR_SEED : lfsr_step(value_o);
    end
endmodule

// File: rtl/platform_scheduler.sv
// platform_scheduler: per-frame scroll burst and platform-group recycle scheduler.
//   clk, rst: clock and synchronous active-high reset
//   bus:      platform_scheduler_if.master (frame_tick/collision/group_y in,
//             scroll and recycle commands, busy, overrun, score out)
//   Build option: define PLATFORM_SCORE_EN to count scroll frames on score (else score is 0).
module platform_scheduler import platform_pkg::*; #(
    parameter coord_t EARTH = DEF_EARTH,
    parameter coord_t SCROLL_DY = DEF_SCROLL_DY,
    parameter int SCROLL_FRAMES = DEF_SCROLL_FRAMES,
    parameter int GROUPS = DEF_GROUPS,
    parameter int GROUP_SIZE = DEF_GROUP_SIZE
) (
    input logic clk,
    input logic rst,
    platform_scheduler_if.master bus
);
    localparam int CW = SCROLL_FRAMES > 1 ? $clog2(SCROLL_FRAMES) : 1;
    state_t                state_q;
    logic [2:0]            grp_q, grp_d, recycle_group_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pending_q, overrun_q, scroll_valid_q, recycle_valid_q;
    logic [GROUP_SIZE-1:0] recycle_mask_q, mask_d;
    logic [14:0]           lfsr;
    logic                  last, hit, want_scroll;
    platform_lfsr u_lfsr (.clk(clk), .rst(rst), .value_o(lfsr));
    // An all-zero draw would leave the group empty, so the top platform is forced on.
    assign mask_d = GROUP_SIZE'(lfsr) | {(lfsr == '0), {(GROUP_SIZE-1){1'b0}}};
    assign grp_d = grp_q + 3'd1;
    assign cnt_d = (cnt_q == CW'(SCROLL_FRAMES-1)) ? '0 : cnt_q + 1'b1;
    assign last = grp_q == 3'(GROUPS-1);
    assign hit = bus.group_y[grp_q] >= EARTH;
    // A nonzero count means a burst is in progress and keeps scrolling until it wraps.
    assign want_scroll = bus.collision | pending_q | (cnt_q != '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            grp_q           <= '0;
            cnt_q           <= '0;
            pending_q       <= 1'b0;
            overrun_q       <= 1'b0;
            scroll_valid_q  <= 1'b0;
            recycle_valid_q <= 1'b0;
            recycle_group_q <= '0;
            recycle_mask_q  <= '0;
        end else begin
            if (state_q != IDLE) begin
                if (bus.frame_tick) overrun_q <= 1'b1;
                if (bus.collision) pending_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (bus.frame_tick) begin
                    pending_q      <= 1'b0;
                    grp_q          <= '0;
                    scroll_valid_q <= want_scroll;
                    state_q        <= want_scroll ? SCROLL : SCAN;
                end
                SCROLL: begin
                    scroll_valid_q <= 1'b0;
                    cnt_q          <= cnt_d;
                    grp_q          <= '0;
                    state_q        <= SCAN;
                end
                SCAN: if (hit) begin
                    state_q         <= RECYCLE;
                    recycle_valid_q <= 1'b1;
                    recycle_group_q <= grp_q;
                    recycle_mask_q  <= mask_d;
                end else begin
                    grp_q   <= last ? '0 : grp_d;
                    state_q <= last ? IDLE : SCAN;
                end
                RECYCLE: if (bus.recycle_ready) begin
                    recycle_valid_q <= 1'b0;
                    grp_q           <= last ? '0 : grp_d;
                    state_q         <= last ? IDLE : SCAN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.scroll_valid  = scroll_valid_q;
    assign bus.scroll_dy     = SCROLL_DY;
    assign bus.recycle_valid = recycle_valid_q;
    assign bus.recycle_group = recycle_group_q;
    assign bus.recycle_mask  = recycle_mask_q;
    assign bus.busy          = state_q != IDLE;
    assign bus.overrun       = overrun_q;
`ifdef PLATFORM_SCORE_EN
    logic [15:0] score_q;
    always_ff @(posedge clk) begin
        if (rst) score_q <= '0;
        else if (scroll_valid_q && score_q != 16'hFFFF) score_q <= score_q + 16'd1;
    end
    assign bus.score = score_q;
`else
    assign bus.score = '0;
`endif
endmodule

// File: doc/platform_scheduler.md
PLATFORM_SCHEDULER -- requirements
Module: platform_scheduler

Interface
REQ-001 SHALL have parameters: EARTH (signed 11-bit, 480, recycle threshold row); SCROLL_DY (11, 12, pixels per scroll frame); SCROLL_FRAMES (16, frames per scroll burst); GROUPS (6, platform groups); GROUP_SIZE (15, platforms per group).
REQ-002 SHALL have ports (name, direction, width, meaning):
 - clk  in  1  clock
 - rst  in  1  reset, synchronous, active-high
 - frame_tick  in  1  one-cycle pulse per video frame
 - collision  in  1  doodle landed on a platform, level
 - group_y  in  GROUPS x 11 signed  top y of first platform in each group
 - scroll_valid  out  1  one-cycle command: add scroll_dy to every platform y
 - scroll_dy  out  11 signed  scroll amount, constant SCROLL_DY
 - recycle_valid  out  1  recycle command pending
 - recycle_ready  in  1  datapath accepts recycle
 - recycle_group  out  3  group index to recycle
 - recycle_mask  out  GROUP_SIZE  activation pattern for recycled group
 - busy  out  1  state != IDLE
 - overrun  out  1  sticky: frame_tick arrived while busy
 - score  out  16  scroll frames taken (SCORE_EN only)

Function
REQ-003 SHALL implement FSM states IDLE, SCROLL, SCAN, RECYCLE.
REQ-004 IDLE: on frame_tick go to SCROLL if (collision | pending | scroll_cnt != 0), else SCAN; pending cleared on this transition.
REQ-005 SCROLL: scroll_valid high exactly one cycle; scroll_cnt increments modulo SCROLL_FRAMES; next state SCAN with grp = 0.
REQ-006 SCAN: one group per cycle; compares group_y[grp] (signed) >= EARTH; on true go to RECYCLE; else grp++; after grp = GROUPS-1 return to IDLE.
REQ-007 SCAN SHALL start no earlier than one cycle after scroll_valid so group_y reflects the scroll.
REQ-008 RECYCLE: recycle_valid high; recycle_group = grp; recycle_mask latched on entry; all three held stable until recycle_valid & recycle_ready; then grp++ and SCAN, or IDLE if grp was GROUPS-1.
REQ-009 recycle_mask SHALL be the 15-bit LFSR value (taps x^15+x^14+1) sampled on RECYCLE entry; if zero, bit GROUP_SIZE-1 forced to 1 (at least one platform active).
REQ-010 LFSR SHALL advance every clock regardless of state.
REQ-011 collision asserted while busy SHALL set pending; consumed at next IDLE frame_tick.
REQ-012 frame_tick while busy SHALL be ignored and set overrun (cleared only by reset).
REQ-013 recycle_ready while recycle_valid low SHALL have no effect.

Reset
REQ-014 On rst: state IDLE, grp 0, scroll_cnt 0, pending 0, overrun 0, scroll_valid 0, recycle_valid 0, recycle_group 0, recycle_mask 0, score 0, LFSR = 15'h4A5; reset mid-RECYCLE drops the command without handshake.

Configuration
REQ-015 Macro PLATFORM_SCORE_EN: defined -> score increments by 1 per scroll_valid, saturating at 16'hFFFF; undefined -> score port driven 0 and counter not synthesised.

Structure
REQ-016 Shared package platform_pkg SHALL hold the state enum, GROUPS, GROUP_SIZE, EARTH, SCROLL_DY defaults and group_y type.
REQ-017 LFSR SHALL be sub-module platform_lfsr (clk, rst, 15-bit value out).

Verification
REQ-018 Reset, frame_tick with collision=0, all group_y = -100 -> no scroll_valid, busy high 6 cycles during SCAN, no recycle_valid.
REQ-019 collision=1 pulse at one frame_tick -> scroll_valid on 16 consecutive frames, scroll_dy=12, then none; score=16 with macro, 0 without.
REQ-020 group_y[2]=480, others -100, recycle_ready held low 5 cycles -> recycle_valid stable with group=2, mask nonzero and unchanged, then accepted; FSM returns IDLE after group 5.
REQ-021 group_y[0]=group_y[5]=500 -> two sequential recycles, groups 0 then 5, each one handshake.
REQ-022 frame_tick while in RECYCLE with ready low -> overrun=1 sticky; collision during busy -> scroll on next frame.
REQ-023 rst asserted in RECYCLE -> next cycle recycle_valid=0, busy=0, LFSR=15'h4A5.
